// File: rtl/ula_pkg.sv
// ula_pkg: shared opcodes, flag bit indices and result-stage bundle
// for the ULA output path.
package ula_pkg;

  localparam int ULA_DATA_W = 16;
  localparam int ULA_TAG_W  = 4;
  localparam int FLAGS_W    = 6;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_NOT = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_INC = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_EQ  = 4'b1010;
  localparam logic [3:0] OP_LT  = 4'b1011;
  localparam logic [3:0] OP_LE  = 4'b1100;

  localparam int FLAG_Z   = 0;
  localparam int FLAG_N   = 1;
  localparam int FLAG_C   = 2;
  localparam int FLAG_V   = 3;
  localparam int FLAG_DZ  = 4;
  localparam int FLAG_ERR = 5;

  typedef struct packed {
    logic [ULA_DATA_W-1:0] result;
    logic [FLAGS_W-1:0]    flags;
    logic [ULA_TAG_W-1:0]  tag;
  } entry_t;

endpackage

// File: rtl/ula_flag_gen.sv
// ula_flag_gen: applies result fixups and derives status flags
// from op and operands.
module ula_flag_gen
  import ula_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]         op,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [DATA_W-1:0]  ula_result,
  output logic [DATA_W-1:0]  result,
  output logic [FLAGS_W-1:0] flags
);

  localparam int M = DATA_W - 1;

  logic dz;
  logic illegal;
  logic add_cin;
  logic sub_cin;
  logic mul_ovf;

  assign dz      = (op == OP_DIV) && (b == '0);
  assign illegal = (op > OP_LE);

  // carry into the sign bit; signed overflow = cin ^ cout there
  assign add_cin = a[M-1:0] > ~b[M-1:0];
  assign sub_cin = a[M-1:0] >= b[M-1:0];

  assign mul_ovf =
    ({{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b})
    > {{DATA_W{1'b0}}, {DATA_W{1'b1}}};

  always_comb begin
    result = ula_result;
    flags  = '0;
    unique case (1'b1)
      dz: begin
        result          = '1;
        flags[FLAG_DZ]  = 1'b1;
      end
      illegal: begin
        result          = '0;
        flags[FLAG_ERR] = 1'b1;
      end
      default: ;
    endcase
    unique case (op)
      OP_ADD: begin
        flags[FLAG_C] = a > ~b;
        flags[FLAG_V] = (a[M] == b[M]) && (add_cin != a[M]);
      end
      OP_SUB: begin
        flags[FLAG_C] = a < b;
        flags[FLAG_V] = (a[M] != b[M]) && (sub_cin != a[M]);
      end
      OP_INC: begin
        flags[FLAG_C] = &a;
        flags[FLAG_V] = (a == {1'b0, {M{1'b1}}});
      end
      OP_MUL: flags[FLAG_V] = mul_ovf;
      default: ;
    endcase
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[M];
  end

endmodule

// File: rtl/ula_result_stage.sv
// ula_result_stage: registered ULA result/flag stage with 2-entry skid.
// Optional sticky flag accumulator: define ULA_STICKY_FLAGS_EN.
module ula_result_stage
  import ula_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [DATA_W-1:0]  ula_result,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [TAG_W-1:0]   out_tag
`ifdef ULA_STICKY_FLAGS_EN
  ,
  input  logic               sticky_clr,
  output logic [FLAGS_W-1:0] sticky_flags
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [FLAGS_W-1:0] flags;
    logic [TAG_W-1:0]   tag;
  } slot_t;

  logic [DATA_W-1:0]  cap_result;
  logic [FLAGS_W-1:0] cap_flags;
  slot_t cap;
  slot_t out_q;
  slot_t skid_q;
  logic  out_v;
  logic  skid_v;
  logic  accept;
  logic  xfer;

  ula_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .op         (in_op),
    .a          (in_a),
    .b          (in_b),
    .ula_result (ula_result),
    .result     (cap_result),
    .flags      (cap_flags)
  );

  assign cap    = {cap_result, cap_flags, in_tag};
  assign accept = in_valid & in_ready;
  assign xfer   = out_v & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (xfer) begin
      // skid full implies no accept this cycle
      if (skid_v) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end else if (accept) begin
        out_q <= cap;
      end else begin
        out_v <= 1'b0;
      end
    end else if (accept) begin
      if (out_v) begin
        skid_q <= cap;
        skid_v <= 1'b1;
      end else begin
        out_q <= cap;
        out_v <= 1'b1;
      end
    end
  end

  assign in_ready   = ~skid_v;
  assign out_valid  = out_v;
  assign out_result = out_q.result;
  assign out_flags  = out_q.flags;
  assign out_tag    = out_q.tag;

`ifdef ULA_STICKY_FLAGS_EN
  logic [FLAGS_W-1:0] sticky_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_clr ? '0 : sticky_q)
                | (xfer ? out_q.flags : '0);
    end
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_ula_result_stage.sv
// tb_ula_result_stage: scoreboard bench for ula_result_stage,
// directed corner ops plus randomized traffic against a reference model.
module tb_ula_result_stage;
  import ula_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] ula_result;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [5:0]  out_flags;
  logic [3:0]  out_tag;
`ifdef ULA_STICKY_FLAGS_EN
  logic        sticky_clr;
  logic [5:0]  sticky_flags;
`endif

  ula_result_stage #(.DATA_W(16), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .ula_result (ula_result),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_tag    (out_tag)
`ifdef ULA_STICKY_FLAGS_EN
    ,
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  always #5 clk = ~clk;

  entry_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int rdy_mode = 0;

  // ULA stand-in: what the upstream ULA would drive
  function automatic logic [15:0] ula_model(input logic [3:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    logic [31:0] p;
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a ^ b;
      4'd3: return ~a;
      4'd4: return a << b[3:0];
      4'd5: return a + b;
      4'd6: return a - b;
      4'd7: return a + 16'd1;
      4'd8: begin
        p = {16'd0, a} * {16'd0, b};
        return p[15:0];
      end
      4'd9: return (b == 16'd0) ? 16'd0 : a / b;
      4'd10: return (a == b) ? 16'd1 : 16'd0;
      4'd11: return (a < b) ? 16'd1 : 16'd0;
      4'd12: return (a <= b) ? 16'd1 : 16'd0;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic entry_t ref_model(input logic [3:0] op,
                                       input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic [15:0] u,
                                       input logic [3:0] tag);
    entry_t e;
    longint ua, ub, sa, sbv, r;
    ua = a; ub = b;
    sa = $signed(a); sbv = $signed(b);
    e.result = u;
    e.flags = '0;
    e.tag = tag;
    if (op == 4'd9 && b == 16'd0) begin
      e.result = 16'hFFFF;
      e.flags[FLAG_DZ] = 1'b1;
    end else if (op >= 4'd13) begin
      e.result = 16'h0000;
      e.flags[FLAG_ERR] = 1'b1;
    end
    case (op)
      4'd5: begin
        r = sa + sbv;
        e.flags[FLAG_C] = (ua + ub) > 65535;
        e.flags[FLAG_V] = (r > 32767) || (r < -32768);
      end
      4'd6: begin
        r = sa - sbv;
        e.flags[FLAG_C] = ua < ub;
        e.flags[FLAG_V] = (r > 32767) || (r < -32768);
      end
      4'd7: begin
        e.flags[FLAG_C] = (ua == 65535);
        e.flags[FLAG_V] = (sa + 1) > 32767;
      end
      4'd8: e.flags[FLAG_V] = (ua * ub) > 65535;
      default: ;
    endcase
    e.flags[FLAG_Z] = (e.result == 16'd0);
    e.flags[FLAG_N] = e.result[15];
    return e;
  endfunction

  task automatic send(input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] tag,
                      input bit use_exp, input logic [15:0] er,
                      input logic [5:0] ef);
    entry_t e;
    bit done;
    done = 1'b0;
    in_op = op; in_a = a; in_b = b; in_tag = tag;
    ula_result = ula_model(op, a, b);
    e = ref_model(op, a, b, ula_result, tag);
    if (use_exp) begin
      e.result = er;
      e.flags = ef;
    end
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        n_acc++;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout tag=%0d in_ready stayed 0, required 1", tag);
    end
  endtask

  task automatic check1(input string name, input logic [15:0] act,
                        input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      2: out_ready = ($urandom % 4) != 0;
      default: ;
    endcase
  end

  entry_t mon_e;
  entry_t prev;
  bit prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if ({out_result, out_flags, out_tag} !== prev) begin
          errors++;
          $display("FAIL stall_hold actual=%h required=%h",
                   {out_result, out_flags, out_tag}, prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output tag=%0d, scoreboard empty", out_tag);
        end else begin
          mon_e = sb.pop_front();
          if (out_result !== mon_e.result || out_flags !== mon_e.flags
              || out_tag !== mon_e.tag) begin
            errors++;
            $display("FAIL output actual res=%h flags=%b tag=%0d required res=%h flags=%b tag=%0d",
                     out_result, out_flags, out_tag,
                     mon_e.result, mon_e.flags, mon_e.tag);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_result, out_flags, out_tag};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    rst = 1'b1;
    in_valid = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; ula_result = '0; in_tag = '0;
    out_ready = 1'b0;
`ifdef ULA_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check1("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check1("rst_out_result", out_result, 16'd0);
    check1("rst_out_flags", {10'd0, out_flags}, 16'd0);
    check1("rst_out_tag", {12'd0, out_tag}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 1;
    @(posedge clk); #1;

    send(4'd5, 16'hFFFF, 16'h0001, 4'd1, 1, 16'h0000, 6'b000101);
    @(negedge clk);
    check1("latency_out_valid", {15'd0, out_valid}, 16'd1);
    @(posedge clk); #1;
    send(4'd5, 16'h7FFF, 16'h0001, 4'd2, 1, 16'h8000, 6'b001010);
    send(4'd6, 16'h0003, 16'h0005, 4'd3, 1, 16'hFFFE, 6'b000110);
    send(4'd9, 16'h0010, 16'h0000, 4'd4, 1, 16'hFFFF, 6'b010010);
    send(4'd14, 16'h1234, 16'h5678, 4'd5, 1, 16'h0000, 6'b100001);
    send(4'd8, 16'h0100, 16'h0100, 4'd6, 1, 16'h0000, 6'b001001);
    repeat (3) @(posedge clk); #1;

    rdy_mode = 0;
    @(posedge clk); #1;
    n_acc = 0;
    fork
      begin
        for (int t = 1; t <= 4; t++)
          send(4'($urandom_range(0, 12)), 16'($urandom), 16'($urandom),
               4'(t), 0, 16'd0, 6'd0);
      end
      begin
        repeat (8) @(negedge clk);
        check1("bp_accepts", 16'(n_acc), 16'd2);
        check1("bp_in_ready", {15'd0, in_ready}, 16'd0);
        rdy_mode = 1;
      end
    join
    repeat (4) @(posedge clk); #1;
    check1("bp_drained", 16'(sb.size()), 16'd0);

    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    send(4'd5, 16'h0001, 16'h0002, 4'd7, 0, 16'd0, 6'd0);
    send(4'd5, 16'h0003, 16'h0004, 4'd8, 0, 16'd0, 6'd0);
    @(negedge clk);
    check1("full_in_ready", {15'd0, in_ready}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check1("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    check1("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    check1("midrst_out_result", out_result, 16'd0);
    sb.delete();
    @(posedge clk); #1;

`ifdef ULA_STICKY_FLAGS_EN
    rdy_mode = 1;
    @(posedge clk); #1;
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    send(4'd9, 16'h0010, 16'h0000, 4'd9, 0, 16'd0, 6'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("sticky_dz", {10'd0, sticky_flags}, 16'h0012);
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    send(4'd5, 16'hFFFF, 16'h0002, 4'd10, 0, 16'd0, 6'd0);
    rdy_mode = 3;
    @(posedge clk); #2;
    out_ready = 1'b1;
    sticky_clr = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    sticky_clr = 1'b0;
    @(negedge clk);
    check1("sticky_clr_xfer", {10'd0, sticky_flags}, 16'h0004);
    rdy_mode = 1;
    repeat (2) @(posedge clk); #1;
`endif

    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom % 4 == 0) begin
        @(posedge clk); #1;
      end
      op = 4'($urandom_range(0, 15));
      a = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
      b = ($urandom % 8 == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom % 8 == 0) a = 16'h7FFF;
      send(op, a, b, 4'(i), 0, 16'd0, 6'd0);
    end

    rdy_mode = 1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("final_drain", 16'(sb.size()), 16'd0);
    check1("final_out_valid", {15'd0, out_valid}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_result_stage.md
Name: ula_result_stage

Overview:
Registered output stage directly downstream of the 16-bit ULA. Captures the ULA's combinational result with its op and operands, and derives status flags the ULA does not expose: zero, negative, carry/borrow, overflow, divide-by-zero and illegal-op. Delivers result, flags and tag to the consumer over a valid/ready handshake through a 2-entry skid buffer, giving full throughput with registered ready.

Parameters:
DATA_W, 16, operand/result width; must match the ULA (16); must be >=4.
TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream presents op/a/b/ula_result/in_tag
in_ready  output  1  stage can accept this cycle (registered)
in_op  input  4  ULA opcode driven to the ULA this cycle
in_a  input  DATA_W  operand a as driven to the ULA
in_b  input  DATA_W  operand b as driven to the ULA
ula_result  input  DATA_W  ULA combinational result for in_op/in_a/in_b
in_tag  input  TAG_W  opaque tag
out_valid  output  1  output entry valid
out_ready  input  1  consumer accepts
out_result  output  DATA_W  final result
out_flags  output  6  {ERR, DZ, V, C, N, Z}
out_tag  output  TAG_W  tag of the output entry

Behaviour:
- Reset: out_valid=0, in_ready=1, out_result=0, out_flags=0, out_tag=0; skid entry invalid. Reset mid-transfer discards both entries; no partial output.
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- Latency: accept in cycle N -> out_valid in N+1 when empty. Throughput: 1 op/cycle while out_ready=1.
- Skid: in_ready = ~skid_valid (registered). If out is occupied and not draining on accept, the entry goes to skid and in_ready drops next cycle. On transfer with skid valid, skid moves to out and in_ready rises next cycle. Accept plus transfer in the same cycle with skid empty: the new entry replaces out directly.
- Ordering is strict FIFO. No entry is ever dropped or duplicated.
- Result fixups, applied at capture:
  - DIV (1001) with b==0: result forced to all-ones, DZ=1.
  - Ops 1101-1111 (illegal): result forced to 0, ERR=1.
  - Otherwise result = ula_result.
- Flags (from the final result):
  - Z = result==0.
  - N = result[DATA_W-1].
  - C: ADD (0101) = carry out of a+b. SUB (0110) = borrow (a<b unsigned). INC (0111) = (a==all-ones). 0 for all other ops.
  - V: ADD/SUB/INC = two's-complement signed overflow. MUL (1000) = upper DATA_W bits of the full 2*DATA_W product nonzero. 0 otherwise.
  - DZ and ERR as above; 0 otherwise.
- Flags are computed from in_a/in_b, not from ULA internals. Compare ops (1010-1100) give result 0/1 and only Z/N are meaningful.
- Outputs hold stable while out_valid & ~out_ready.

Optional Feature:
ULA_STICKY_FLAGS_EN
- Defined: adds input sticky_clr (1) and output sticky_flags (6).
  - On every transfer, out_flags are OR-ed into sticky_flags.
  - sticky_clr clears the accumulated value. If a transfer occurs in the same cycle, that transfer's flags are still OR-ed in after the clear.
  - Reset value is 0.
- Undefined: no extra ports or logic.

Decomposition:
- Shared package ula_pkg:
  - opcode localparams OP_AND..OP_LE (0000-1100)
  - flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3, FLAG_DZ=4, FLAG_ERR=5
  - FLAGS_W=6
  - entry struct {result, flags, tag}
- One sub-module: ula_flag_gen. Combinational op/a/b/ula_result -> final result + flags. The skid/handshake logic stays in ula_result_stage.

Test Plan:
- ADD a=16'hFFFF, b=16'h0001, out_ready=1 -> next cycle out_result=16'h0000, flags Z=1, C=1, V=0, N=0.
- ADD a=16'h7FFF, b=16'h0001 -> out_result=16'h8000, N=1, V=1, C=0. SUB a=3, b=5 -> 16'hFFFE, C=1, N=1.
- DIV a=16'h0010, b=0 -> out_result=16'hFFFF, DZ=1. Op 4'b1110 -> out_result=0, ERR=1, Z=1.
- Back-pressure: 4 back-to-back ops (tags 1-4) with out_ready=0 -> in_ready falls after 2 accepts. Release out_ready -> tags emerge 1,2,3,4 with no loss or duplication and outputs stable while stalled.
- MUL a=16'h0100, b=16'h0100 -> out_result=0, V=1, Z=1. Random valid/ready over 1000 ops checked against a reference model.
- Assert rst with 2 entries held -> next cycle out_valid=0, in_ready=1. With ULA_STICKY_FLAGS_EN: DZ op then sticky_clr pulse coincident with a C-setting transfer -> sticky_flags shows only C.
